// File: rtl/peripheral_timmer_multi.sv
// Multi-channel programmable timer on the J1 I/O bus: per-channel prescaler, down-counter,
// reload, one-shot/periodic mode and sticky expiry flag. Optional irq output under `TIMMER_IRQ_EN`.
`timescale 1ns/1ps
module peripheral_timmer_multi #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 16,
    parameter int PSC_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [15:0]     d_in,
    input  logic            cs,
    input  logic [3:0]      addr,
    input  logic            rd,
    input  logic            wr,
    output logic [15:0]     d_out,
    output logic [N_CH-1:0] tick_out
`ifdef TIMMER_IRQ_EN
    ,
    output logic            irq
`endif
);

    logic [N_CH-1:0]  r_en;
    logic [N_CH-1:0]  r_per;
    logic [N_CH-1:0]  r_exp;
    logic [N_CH-1:0]  r_tick;
    logic [PSC_W-1:0] r_psc    [N_CH];
    logic [PSC_W-1:0] r_pcnt   [N_CH];
    logic [CNT_W-1:0] r_reload [N_CH];
    logic [CNT_W-1:0] r_count  [N_CH];
    logic [15:0]      r_dout;
`ifdef TIMMER_IRQ_EN
    logic [N_CH-1:0]  r_irqen;
    logic             r_irq;
`endif

    logic [N_CH-1:0]  w_sel;
    logic [N_CH-1:0]  w_ctrl_wr;
    logic [N_CH-1:0]  w_reload_wr;
    logic [N_CH-1:0]  w_status_wr;
    logic [N_CH-1:0]  w_ctick;
    logic [N_CH-1:0]  w_expire;
    logic [N_CH-1:0]  w_irqen_rd;
    logic [15:0]      w_rdata;
    logic [15:0]      w_unused_din;

    assign w_unused_din = d_in;

`ifdef TIMMER_IRQ_EN
    assign w_irqen_rd = r_irqen;
`else
    assign w_irqen_rd = '0;
`endif

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch is inferred.
        w_sel       = '0;
        w_ctrl_wr   = '0;
        w_reload_wr = '0;
        w_status_wr = '0;
        w_ctick     = '0;
        w_expire    = '0;
        for (int c = 0; c < N_CH; c++) begin
            w_sel[c]       = (addr[3:2] == 2'(c));
            w_ctrl_wr[c]   = cs && wr && w_sel[c] && (addr[1:0] == 2'd0);
            w_reload_wr[c] = cs && wr && w_sel[c] && (addr[1:0] == 2'd1);
            w_status_wr[c] = cs && wr && w_sel[c] && (addr[1:0] == 2'd3);
            w_ctick[c]     = r_en[c] && (r_pcnt[c] == r_psc[c]);
            w_expire[c]    = w_ctick[c] && (r_count[c] == '0);
        end
    end

    always_comb begin
        w_rdata = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (w_sel[c]) begin
                case (addr[1:0])
                    2'd0:    w_rdata = {8'(r_psc[c]), 5'd0, w_irqen_rd[c], r_per[c], r_en[c]};
                    2'd1:    w_rdata = 16'(r_reload[c]);
                    2'd2:    w_rdata = 16'(r_count[c]);
                    default: w_rdata = {15'd0, r_exp[c]};
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_en   <= '0;
            r_per  <= '0;
            r_exp  <= '0;
            r_tick <= '0;
`ifdef TIMMER_IRQ_EN
            r_irqen <= '0;
`endif
            for (int c = 0; c < N_CH; c++) begin
                r_psc[c]    <= '0;
                r_pcnt[c]   <= '0;
                r_reload[c] <= '0;
                r_count[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                // NOTE: state uses non-blocking assignments so every channel sees pre-edge values.
                if (w_ctrl_wr[c]) begin
                    r_en[c]  <= d_in[0];
                    r_per[c] <= d_in[1];
                    r_psc[c] <= d_in[8 +: PSC_W];
`ifdef TIMMER_IRQ_EN
                    r_irqen[c] <= d_in[2];
`endif
                end else if (w_expire[c] && !r_per[c]) begin
                    r_en[c] <= 1'b0;
                end

                if (w_reload_wr[c])
                    r_reload[c] <= d_in[CNT_W-1:0];

                // A re-arming CTRL write on a one-shot expiry reloads instead of leaving COUNT at 0.
                if (w_ctrl_wr[c] && d_in[0] && !r_en[c]) begin
                    r_count[c] <= r_reload[c];
                    r_pcnt[c]  <= '0;
                end else if (r_en[c]) begin
                    r_pcnt[c] <= w_ctick[c] ? '0 : r_pcnt[c] + PSC_W'(1);
                    if (w_ctick[c]) begin
                        if (r_count[c] != '0)
                            r_count[c] <= r_count[c] - CNT_W'(1);
                        else if (r_per[c] || (w_ctrl_wr[c] && d_in[0]))
                            r_count[c] <= r_reload[c];
                    end
                end else if (w_reload_wr[c]) begin
                    r_count[c] <= d_in[CNT_W-1:0];
                end

                r_tick[c] <= w_expire[c];
                if (w_expire[c])
                    r_exp[c] <= 1'b1;
                else if (w_status_wr[c] && d_in[0])
                    r_exp[c] <= 1'b0;
            end
        end
    end

    // Read data is captured mid-cycle so the J1 sees it at the next rising edge.
    always_ff @(negedge clk) begin
        if (rst)
            r_dout <= '0;
        else if (cs && rd)
            r_dout <= w_rdata;
        else
            r_dout <= '0;
    end

`ifdef TIMMER_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst)
            r_irq <= 1'b0;
        else
            r_irq <= |(r_exp & r_irqen);
    end
    assign irq = r_irq;
`endif

    assign d_out    = r_dout;
    assign tick_out = r_tick;

endmodule

// File: tb/tb_peripheral_timmer_multi.sv
// Directed bench for peripheral_timmer_multi: register table plus timing sequences per channel.
`timescale 1ns/1ps
module tb_peripheral_timmer_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] d_in;
    logic        cs;
    logic [3:0]  addr;
    logic        rd;
    logic        wr;
    logic [15:0] d_out;
    logic [3:0]  tick_out;
`ifdef TIMMER_IRQ_EN
    logic        irq;
`endif

    peripheral_timmer_multi dut (
        .clk      (clk),
        .rst      (rst),
        .d_in     (d_in),
        .cs       (cs),
        .addr     (addr),
        .rd       (rd),
        .wr       (wr),
        .d_out    (d_out),
        .tick_out (tick_out)
`ifdef TIMMER_IRQ_EN
        ,
        .irq      (irq)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int wcyc    = 0;
    int tcnt [4] = '{0, 0, 0, 0};
    int tlast[4] = '{0, 0, 0, 0};
    int tgap [4] = '{0, 0, 0, 0};

    always @(posedge clk) cyc <= cyc + 1;

    // Tick log: count, time of last pulse and spacing to the previous one, per channel.
    always @(negedge clk) begin
        for (int c = 0; c < 4; c++) begin
            if (tick_out[c]) begin
                tgap[c]  = cyc - tlast[c];
                tlast[c] = cyc;
                tcnt[c]  = tcnt[c] + 1;
            end
        end
    end

    typedef struct {
        logic        is_wr;
        logic [3:0]  addr;
        logic [15:0] data;
        logic [15:0] expv;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [15:0] d);
        cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
        @(posedge clk); #1;
        cs = 1'b0; wr = 1'b0;
        wcyc = cyc;
    endtask

    task automatic rd_reg(input logic [3:0] a, output logic [15:0] d);
        cs = 1'b1; rd = 1'b1; addr = a;
        @(posedge clk); #1;
        d = d_out;
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic chk_rd(input logic [3:0] a, input logic [15:0] exp, input string name);
        logic [15:0] v;
        rd_reg(a, v);
        check(name, 32'(v), 32'(exp));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int w0;
        logic [15:0] v;

        vecs[0]  = '{1'b1, 4'h0, 16'hA502, 16'h0000};
        vecs[1]  = '{1'b0, 4'h0, 16'h0000, 16'hA502};
`ifdef TIMMER_IRQ_EN
        vecs[2]  = '{1'b1, 4'h0, 16'hFFFE, 16'h0000};
        vecs[3]  = '{1'b0, 4'h0, 16'h0000, 16'hFF06};
`else
        vecs[2]  = '{1'b1, 4'h0, 16'hFFFE, 16'h0000};
        vecs[3]  = '{1'b0, 4'h0, 16'h0000, 16'hFF02};
`endif
        vecs[4]  = '{1'b1, 4'h1, 16'h1234, 16'h0000};
        vecs[5]  = '{1'b0, 4'h1, 16'h0000, 16'h1234};
        vecs[6]  = '{1'b0, 4'h2, 16'h0000, 16'h1234};
        vecs[7]  = '{1'b1, 4'h2, 16'h5555, 16'h0000};
        vecs[8]  = '{1'b0, 4'h2, 16'h0000, 16'h1234};
        vecs[9]  = '{1'b1, 4'h3, 16'h0000, 16'h0000};
        vecs[10] = '{1'b0, 4'h3, 16'h0000, 16'h0000};
        vecs[11] = '{1'b1, 4'h5, 16'hBEEF, 16'h0000};
        vecs[12] = '{1'b0, 4'h6, 16'h0000, 16'hBEEF};
        vecs[13] = '{1'b0, 4'h4, 16'h0000, 16'h0000};

        rst = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; d_in = '0;
        idle(3);
        check("reset_dout", 32'(d_out), 32'h0);
        check("reset_tick", 32'(tick_out), 32'h0);
        rst = 1'b0;
        idle(1);

        for (int a = 0; a < 16; a++)
            chk_rd(4'(a), 16'h0000, $sformatf("reset_rd_%0h", a));
        check("reset_tick_after", 32'(tick_out), 32'h0);

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].is_wr)
                wr_reg(vecs[i].addr, vecs[i].data);
            else
                chk_rd(vecs[i].addr, vecs[i].expv, $sformatf("regtab_%0d", i));
        end

        cs = 1'b0; rd = 1'b1; addr = 4'h1;
        idle(1);
        check("rd_without_cs", 32'(d_out), 32'h0);
        rd = 1'b0;

        // Channel 0: periodic, PSC=0, RELOAD=3 -> pulse every 4 clocks.
        base = tcnt[0];
        wr_reg(4'h1, 16'd3);
        wr_reg(4'h0, 16'h0003);
        w0 = wcyc;
        idle(13);
        check("ch0_tick_count", 32'(tcnt[0] - base), 32'd3);
        check("ch0_last_tick", 32'(tlast[0] - w0), 32'd12);
        check("ch0_period", 32'(tgap[0]), 32'd4);
        chk_rd(4'h3, 16'h0001, "ch0_exp_set");
        wr_reg(4'h0, 16'h0000);
        wr_reg(4'h3, 16'h0001);
        chk_rd(4'h3, 16'h0000, "ch0_exp_cleared");

        // Channel 1: one-shot, PSC=4, RELOAD=2 -> single pulse 15 clocks later.
        base = tcnt[1];
        wr_reg(4'h5, 16'd2);
        wr_reg(4'h4, 16'h0401);
        w0 = wcyc;
        idle(20);
        check("ch1_tick_count", 32'(tcnt[1] - base), 32'd1);
        check("ch1_tick_time", 32'(tlast[1] - w0), 32'd15);
        chk_rd(4'h4, 16'h0400, "ch1_ctrl_after");
        chk_rd(4'h6, 16'h0000, "ch1_count_after");
        chk_rd(4'h7, 16'h0001, "ch1_exp");

        // Channel 2: periodic RELOAD=0 expires every tick; clear on an expiry cycle loses.
        wr_reg(4'h9, 16'd0);
        wr_reg(4'h8, 16'h0003);
        w0 = wcyc;
        idle(4);
        check("ch2_every_cycle", 32'(tgap[2]), 32'd1);
        check("ch2_last_tick", 32'(tlast[2] - w0), 32'd3);
        wr_reg(4'hB, 16'h0001);
        chk_rd(4'hB, 16'h0001, "ch2_set_wins_periodic");
        wr_reg(4'h8, 16'h0000);
        wr_reg(4'hB, 16'h0001);
        chk_rd(4'hB, 16'h0000, "ch2_exp_cleared");

        // One-shot expiry coinciding with an EN=1 CTRL write re-arms from RELOAD.
        wr_reg(4'h9, 16'd2);
        wr_reg(4'h8, 16'h0001);
        w0 = wcyc;
        idle(2);
        wr_reg(4'h8, 16'h0001);
        idle(6);
        check("ch2_rearm_last", 32'(tlast[2] - w0), 32'd6);
        check("ch2_rearm_gap", 32'(tgap[2]), 32'd3);
        chk_rd(4'h8, 16'h0000, "ch2_rearm_ctrl");

        // One-shot expiry together with an EXP-clear write.
        wr_reg(4'hB, 16'h0001);
        chk_rd(4'hB, 16'h0000, "ch2_pre_clear");
        wr_reg(4'h9, 16'd0);
        wr_reg(4'h8, 16'h0001);
        w0 = wcyc;
        wr_reg(4'hB, 16'h0001);
        chk_rd(4'hB, 16'h0001, "ch2_set_wins_oneshot");
        check("ch2_oneshot_time", 32'(tlast[2] - w0), 32'd1);
        wr_reg(4'hB, 16'h0000);
        chk_rd(4'hB, 16'h0001, "ch2_write0_noeffect");

`ifdef TIMMER_IRQ_EN
        check("irq_idle", 32'(irq), 32'd0);
        wr_reg(4'h1, 16'd0);
        wr_reg(4'h0, 16'h0005);
        idle(3);
        check("irq_set", 32'(irq), 32'd1);
        wr_reg(4'h3, 16'h0001);
        check("irq_hold_one_cycle", 32'(irq), 32'd1);
        idle(1);
        check("irq_cleared", 32'(irq), 32'd0);
        wr_reg(4'h0, 16'h0001);
        idle(3);
        chk_rd(4'h3, 16'h0001, "irq_off_exp");
        check("irq_masked", 32'(irq), 32'd0);
`endif

        // Channel 3: RELOAD change mid-count affects only the following periods; then reset.
        base = tcnt[3];
        wr_reg(4'hD, 16'd10);
        wr_reg(4'hC, 16'h0003);
        w0 = wcyc;
        idle(2);
        wr_reg(4'hD, 16'd5);
        idle(18);
        check("ch3_tick_count", 32'(tcnt[3] - base), 32'd2);
        check("ch3_last_tick", 32'(tlast[3] - w0), 32'd17);
        check("ch3_new_period", 32'(tgap[3]), 32'd6);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        base = tcnt[3];
        chk_rd(4'hE, 16'h0000, "ch3_count_reset");
        chk_rd(4'hC, 16'h0000, "ch3_ctrl_reset");
        chk_rd(4'hD, 16'h0000, "ch3_reload_reset");
        idle(20);
        check("ch3_no_ticks_after_rst", 32'(tcnt[3] - base), 32'd0);
        check("tick_after_rst", 32'(tick_out), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
